dct_row_quant: RTL and testbench
================================

Name: dct_row_quant

Overview:
- Downstream consumer of the DCT output stage's even/odd coefficient pairs (e1/o1).
- Collects one 8-coefficient row from 4 pairs and quantizes each coefficient by a per-position power-of-two divisor.
- Streams the quantized row serially to the zig-zag/entropy stage over a valid/ready handshake.
- Tracks rows so the last coefficient of each 8x8 block is flagged.

Parameters:
- QSHIFT, 24'h8DA448, packed per-position right-shift amounts: position i uses bits [3i+2:3i]. Default is 0,1,1,2,2,3,3,4 for positions 0..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- e1  in  8  even coefficient, signed two's complement
- o1  in  8  odd coefficient, signed two's complement
- in_valid  in  1  e1/o1 pair valid
- in_ready  out  1  block accepts a pair this cycle
- out_data  out  8  quantized coefficient, signed
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  last (8th) coefficient of the row
- out_blk_last  out  1  last coefficient of the 8th row of a block

Behaviour:
- Reset (rst=0, async): state FILL, pair count 0, drain index 0, row count 0.
  - in_ready=1.
  - out_valid=0, out_data=0, out_last=0, out_blk_last=0.
  - Row buffer contents don't-care.
- State FILL:
  - in_ready=1.
  - On in_valid&in_ready, e1 is written to buffer position 2k and o1 to position 2k+1, where k is the pair count (0..3); k then increments.
  - On acceptance of pair k=3: next state DRAIN, in_ready=0 from the next cycle.
  - out_data is loaded with q(pos0), out_valid=1, and out_last=0 in the same edge.
  - Latency: 4th pair accepted at edge N, so the first output is visible after edge N.
- State DRAIN:
  - in_ready=0; in_valid is ignored and no buffer writes occur.
  - out_data, out_valid, out_last and out_blk_last are registered and stay stable while out_valid&!out_ready.
  - On out_valid&out_ready with index<7: the index increments and out_data loads q(pos index+1).
  - out_last=1 exactly while position 7 is presented.
  - out_blk_last=1 while position 7 is presented and row count==7.
  - On the handshake of position 7: out_valid=0, flags clear, the row count increments (wrapping 7 to 0), pair count resets to 0, next state FILL, and in_ready=1 the next cycle.
  - There is no bubble-free overlap: the next row fill starts only after the drain completes.
- Quantizer q(x) with s = QSHIFT[position]:
  - 9-bit signed intermediate; result is always 8-bit signed with no saturation needed.
  - s=0 means the result equals x.
  - Default mode truncates toward zero: x>=0 gives x>>>s; x<0 gives (x + 2^s − 1)>>>s.
  - Shift values 0..7 are all legal.
  - With s=7: −128 gives −1 and 127 gives 0.
- Reset asserted mid-FILL or mid-DRAIN:
  - Any partial row is discarded and out_valid drops immediately.
  - Row count returns to 0.
- Simultaneous events:
  - in_valid during DRAIN is not accepted; upstream must hold its pair.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro QUANT_ROUND_EN.
- Defined: q(x) rounds half away from zero for s>0.
  - x>=0 gives (x + 2^(s−1))>>s.
  - x<0 gives −((−x + 2^(s−1))>>s).
  - Evaluated in 9 bits; s=0 still passes x through.
- Undefined: truncation toward zero as above. No other behaviour, timing or port differs.

Test Plan:
- Basic row (default QSHIFT, truncation):
  - Stimulus: pairs (40,21),(8,−8),(−16,16),(−5,100) with out_ready=1.
  - Response: out_data sequence 40,10,4,−2,−4,2,0,6; out_last only on the 8th; first out_valid the cycle after the 4th pair; in_ready=0 throughout the drain.
- Rounding (QUANT_ROUND_EN defined):
  - Stimulus: same pairs as the basic row.
  - Response: 40,11,4,−2,−4,2,−1,6.
- Backpressure:
  - Stimulus: same row with out_ready=0 for 5 cycles after out_valid rises, then 1.
  - Response: out_data=40 and out_valid=1 held stable for the full stall; no coefficient lost or duplicated; in_valid pulses during the drain are not accepted.
- Block flag:
  - Stimulus: 8 back-to-back rows, all pairs (1,1).
  - Response: out_last on all 8 rows; out_blk_last only on the 64th coefficient. A 9th row shows out_blk_last=0 (row count wrapped).
- Reset mid-operation:
  - Stimulus: rst=0 asserted after 2 pairs accepted, and separately during drain index 3.
  - Response: out_valid=0 and in_ready=1 immediately after release. The next row of 4 pairs (127,−128),(0,0),(0,0),(0,0) with QSHIFT=24'hFFFFFF yields 0,−1,0,0,0,0,0,0.
- Extremes (QSHIFT=0):
  - Stimulus: pairs (127,−128) ×4.
  - Response: output equals input exactly: 127,−128 repeated.

Source files
------------

// File: rtl/dct_row_quant.sv
// dct_row_quant: collects four even/odd DCT coefficient pairs into an 8-entry row, quantizes each
// coefficient by a per-position right shift and streams the row out. Define QUANT_ROUND_EN for rounding.
module dct_row_quant #(
    parameter logic [23:0] QSHIFT = 24'h8DA448
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] e1,
    input  logic signed [7:0] o1,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_blk_last
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        pair_cnt_q, pair_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        row_cnt_q, row_cnt_d;
    logic signed [7:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              out_blk_last_q, out_blk_last_d;
    logic signed [7:0] row_q [8];
    logic signed [7:0] row_d [8];
    logic [2:0]        q_pos;
    logic signed [7:0] q_val;

    function automatic logic [2:0] shift_of(input logic [2:0] pos);
        return QSHIFT[3*int'(pos) +: 3];
    endfunction

    // All arithmetic is 9-bit so that the bias add and the negation of -128 cannot overflow.
    function automatic logic signed [7:0] quant(input logic signed [7:0] x, input logic [2:0] s);
        logic signed [8:0] xw;
        logic signed [8:0] bias;
        logic signed [8:0] res;
        xw = {x[7], x};
`ifdef QUANT_ROUND_EN
        if (s == 3'd0) begin
            res = xw;
        end else begin
            bias = 9'sd1 <<< (s - 3'd1);
            if (!x[7]) res = (xw + bias) >>> s;
            else       res = -((-xw + bias) >>> s);
        end
`else
        bias = (9'sd1 <<< s) - 9'sd1;
        if (x[7]) res = (xw + bias) >>> s;
        else      res = xw >>> s;
`endif
        return res[7:0];
    endfunction

    // One shared quantizer: position 0 when launching a row, otherwise the next drain position.
    assign q_pos = (state_q == FILL) ? 3'd0 : idx_q + 3'd1;
    assign q_val = quant(row_q[q_pos], shift_of(q_pos));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d        = state_q;
        pair_cnt_d     = pair_cnt_q;
        idx_d          = idx_q;
        row_cnt_d      = row_cnt_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_blk_last_d = out_blk_last_q;
        row_d          = row_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    row_d[{pair_cnt_q, 1'b0}] = e1;
                    row_d[{pair_cnt_q, 1'b1}] = o1;
                    pair_cnt_d = pair_cnt_q + 2'd1;
                    if (pair_cnt_q == 2'd3) begin
                        state_d        = DRAIN;
                        idx_d          = 3'd0;
                        out_data_d     = q_val;
                        out_valid_d    = 1'b1;
                        out_last_d     = 1'b0;
                        out_blk_last_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q != 3'd7) begin
                        idx_d          = idx_q + 3'd1;
                        out_data_d     = q_val;
                        out_last_d     = (idx_q == 3'd6);
                        out_blk_last_d = (idx_q == 3'd6) && (row_cnt_q == 3'd7);
                    end else begin
                        state_d        = FILL;
                        idx_d          = 3'd0;
                        pair_cnt_d     = 2'd0;
                        row_cnt_d      = row_cnt_q + 3'd1;
                        out_valid_d    = 1'b0;
                        out_last_d     = 1'b0;
                        out_blk_last_d = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= FILL;
            pair_cnt_q     <= 2'd0;
            idx_q          <= 3'd0;
            row_cnt_q      <= 3'd0;
            out_data_q     <= 8'sd0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_blk_last_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pair_cnt_q     <= pair_cnt_d;
            idx_q          <= idx_d;
            row_cnt_q      <= row_cnt_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_blk_last_q <= out_blk_last_d;
        end
    end

    // NOTE: the row buffer is deliberately left out of reset; it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        row_q <= row_d;
    end

    assign in_ready     = (state_q == FILL);
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_blk_last = out_blk_last_q;

endmodule

// File: tb/tb_dct_row_quant.sv
// Bench for dct_row_quant: three instances (default, zero and all-seven shifts) driven in lockstep and
// checked every cycle against a transaction-level row model, plus hand-computed literal rows.
module tb_dct_row_quant;

    localparam logic [23:0] QS [3] = '{24'h8DA448, 24'h000000, 24'hFFFFFF};
    localparam int LIMIT = 200;

    logic              clk;
    logic              rst;
    logic signed [7:0] e1, o1;
    logic              in_valid, out_ready;
    logic              in_ready     [3];
    logic signed [7:0] out_data     [3];
    logic              out_valid    [3];
    logic              out_last     [3];
    logic              out_blk_last [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dct_row_quant #(.QSHIFT(QS[g])) u_dut (
            .clk          (clk),
            .rst          (rst),
            .e1           (e1),
            .o1           (o1),
            .in_valid     (in_valid),
            .in_ready     (in_ready[g]),
            .out_data     (out_data[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready),
            .out_last     (out_last[g]),
            .out_blk_last (out_blk_last[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Quantizer written straight from the arithmetic definition (integer division truncates toward zero).
    function automatic int model_q(input int x, input int s);
        int p;
        p = 1 << s;
`ifdef QUANT_ROUND_EN
        if (s == 0) return x;
        if (x >= 0) return (x + p / 2) / p;
        return -((-x + p / 2) / p);
`else
        return x / p;
`endif
    endfunction

    function automatic int shift_of(input int inst, input int pos);
        logic [23:0] q;
        q = QS[inst];
        return int'(q[3*pos +: 3]);
    endfunction

    // Row-level model: pairs collected, draining flag, presented index, rows completed.
    int m_buf [8];
    int m_cnt  = 0;
    int m_idx  = 0;
    int m_rows = 0;
    bit m_drain = 1'b0;

    int log_data [3][$];
    bit log_last [$];
    bit log_blk  [$];

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) log_data[i].delete();
        log_last.delete();
        log_blk.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
                check($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
                check($sformatf("rst_out_data[%0d]", i), out_data[i], 0);
                check($sformatf("rst_out_last[%0d]", i), out_last[i], 0);
                check($sformatf("rst_out_blk_last[%0d]", i), out_blk_last[i], 0);
            end
            m_cnt = 0; m_idx = 0; m_rows = 0; m_drain = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready[%0d]", i), in_ready[i], !m_drain);
                check($sformatf("out_valid[%0d]", i), out_valid[i], m_drain);
                check($sformatf("out_last[%0d]", i), out_last[i], m_drain && m_idx == 7);
                check($sformatf("out_blk_last[%0d]", i), out_blk_last[i],
                      m_drain && m_idx == 7 && m_rows == 7);
                if (m_drain)
                    check($sformatf("out_data[%0d] pos %0d", i, m_idx), out_data[i],
                          model_q(m_buf[m_idx], shift_of(i, m_idx)));
            end
            if (m_drain && out_ready) begin
                for (int i = 0; i < 3; i++) log_data[i].push_back(int'(out_data[i]));
                log_last.push_back(out_last[0]);
                log_blk.push_back(out_blk_last[0]);
            end
            if (!m_drain) begin
                if (in_valid) begin
                    m_buf[2*m_cnt]   = int'(e1);
                    m_buf[2*m_cnt+1] = int'(o1);
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_drain = 1'b1;
                        m_idx   = 0;
                    end
                end
            end else if (out_ready) begin
                if (m_idx == 7) begin
                    m_drain = 1'b0;
                    m_idx   = 0;
                    m_cnt   = 0;
                    m_rows  = (m_rows + 1) % 8;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic send_pair(input int a, input int b);
        int n;
        e1 = 8'(a);
        o1 = 8'(b);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[0] && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("send_pair_accepted", n < LIMIT, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_row(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int h);
        send_pair(a, b);
        send_pair(c, d);
        send_pair(e, f);
        send_pair(g, h);
    endtask

    task automatic wait_row_done();
        int n;
        n = 0;
        while (n < LIMIT) begin
            @(negedge clk);
            if (out_valid[0] && out_ready && out_last[0]) break;
            n++;
        end
        check("row_done", n < LIMIT, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string name, input int inst, input int exp_row [8]);
        check($sformatf("%s_len", name), log_data[inst].size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_data[inst].size())
                check($sformatf("%s[%0d]", name, i), log_data[inst][i], exp_row[i]);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_rst_out_valid[%0d]", i), out_valid[i], 0);
            check($sformatf("async_rst_in_ready[%0d]", i), in_ready[i], 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("release_out_valid[%0d]", i), out_valid[i], 0);
            check($sformatf("release_in_ready[%0d]", i), in_ready[i], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int basic_row [8];
        int ext_row   [8];
        int rst_row   [8];
`ifdef QUANT_ROUND_EN
        basic_row = '{40, 11, 4, -2, -4, 2, -1, 6};
        rst_row   = '{1, -1, 0, 0, 0, 0, 0, 0};
`else
        basic_row = '{40, 10, 4, -2, -4, 2, 0, 6};
        rst_row   = '{0, -1, 0, 0, 0, 0, 0, 0};
`endif
        ext_row = '{127, -128, 127, -128, 127, -128, 127, -128};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; e1 = '0; o1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Basic row, free-flowing output.
        clear_logs();
        send_row(40, 21, 8, -8, -16, 16, -5, 100);
        check("first_valid_after_4th_pair", out_valid[0], 1);
        check("in_ready_low_in_drain", in_ready[0], 0);
        check("first_data", out_data[0], basic_row[0]);
        wait_row_done();
        check_row("basic", 0, basic_row);
        for (int i = 0; i < 8; i++)
            if (i < log_last.size()) check($sformatf("basic_last[%0d]", i), log_last[i], i == 7);

        // Backpressure: five stalled edges, with stray in_valid pulses during the drain.
        clear_logs();
        out_ready = 1'b0;
        send_row(40, 21, 8, -8, -16, 16, -5, 100);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            e1 = 8'sd99;
            o1 = -8'sd99;
            @(negedge clk);
            check("stall_data", out_data[0], 40);
            check("stall_valid", out_valid[0], 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_row_done();
        check_row("backpressure", 0, basic_row);

        // Block flag over nine rows starting from a fresh row count.
        pulse_reset();
        clear_logs();
        for (int r = 0; r < 9; r++) begin
            send_row(1, 1, 1, 1, 1, 1, 1, 1);
            wait_row_done();
        end
        check("block_len", log_last.size(), 72);
        for (int j = 0; j < 72; j++) begin
            if (j < log_last.size()) begin
                check($sformatf("blk_last[%0d]", j), log_last[j], (j % 8) == 7);
                check($sformatf("blk_blk_last[%0d]", j), log_blk[j], j == 63);
            end
        end

        // Reset after two pairs, then reset at drain index 3.
        send_pair(50, 60);
        send_pair(-70, 80);
        pulse_reset();
        send_row(11, 22, 33, 44, 55, 66, 77, 88);
        repeat (3) @(posedge clk);
        #1;
        check("drain_idx3_data", out_data[1], 44);
        pulse_reset();
        clear_logs();
        send_row(127, -128, 0, 0, 0, 0, 0, 0);
        wait_row_done();
        check_row("after_reset_qshift7", 2, rst_row);

        // Extremes with zero shift pass straight through.
        clear_logs();
        send_row(127, -128, 127, -128, 127, -128, 127, -128);
        wait_row_done();
        check_row("extremes_qshift0", 1, ext_row);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
